// File: rtl/pipeline_pkg.sv
// Shared types and defaults for the fetch/decode pipeline register.
package pipeline_pkg;

    localparam int INSTR_W          = 16;
    localparam int PC_W_DEF         = 32;
    localparam int IMM_FLAG_BIT_DEF = 15;

    typedef enum logic [1:0] {
        FIRST    = 2'd0,
        WAIT_IMM = 2'd1,
        INT1     = 2'd2,
        INT2     = 2'd3
    } state_t;

    // Everything except the PC, which is parameterised per instance.
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [INSTR_W-1:0] imm;
        logic               valid;
        logic               int1;
        logic               int2;
    } slot_t;

    localparam slot_t BUBBLE = '0;

endpackage

// File: rtl/intr_sequencer.sv
// Interrupt request latch and return-PC capture for the INT1/INT2 sequence.
module intr_sequencer
    import pipeline_pkg::*;
#(
    parameter int PC_W = PC_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            int_req,
    input  logic            take_ok,
    input  logic [PC_W-1:0] pc_in,
    output logic            int_pending,
    output logic            int_take,
    output logic [PC_W-1:0] ret_pc
);

    assign int_take = take_ok && int_pending;

    // A pulse arriving on the take edge is dropped, as the request is still pending then.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            int_pending <= 1'b0;
            ret_pc      <= '0;
        end else if (int_take) begin
            int_pending <= 1'b0;
            ret_pc      <= pc_in;
        end else if (int_req) begin
            int_pending <= 1'b1;
        end
    end

endmodule

// File: rtl/reg_fetch_decode.sv
// Fetch-to-decode pipeline register: assembles opcode+immediate pairs and injects interrupt slots.
module reg_fetch_decode
    import pipeline_pkg::*;
#(
    parameter int PC_W         = PC_W_DEF,
    parameter int IMM_FLAG_BIT = IMM_FLAG_BIT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] instr_word,
    input  logic [PC_W-1:0]    pc_in,
    input  logic               fetch_valid,
    output logic               fetch_ready,
    input  logic               stall,
    input  logic               flush,
    input  logic               int_req,
    output logic [INSTR_W-1:0] instr_decode,
    output logic [INSTR_W-1:0] imm_decode,
    output logic [PC_W-1:0]    pc_decode,
    output logic               valid_decode,
    output logic               int1_decode,
    output logic               int2_decode
);

    state_t             state;
    slot_t              slot;
    logic [INSTR_W-1:0] held_instr;
    logic [PC_W-1:0]    held_pc;
    logic               int_pending;
    logic               int_take;
    logic [PC_W-1:0]    ret_pc;
    logic               accept;

    assign fetch_ready = !rst && !stall && !flush &&
                         ((state == FIRST && !int_pending) || state == WAIT_IMM);
    assign accept      = fetch_valid && fetch_ready;

    intr_sequencer #(.PC_W(PC_W)) u_seq (
        .clk         (clk),
        .rst         (rst),
        .int_req     (int_req),
        .take_ok     (state == FIRST && !stall && !flush),
        .pc_in       (pc_in),
        .int_pending (int_pending),
        .int_take    (int_take),
        .ret_pc      (ret_pc)
    );

    assign instr_decode = slot.instr;
    assign imm_decode   = slot.imm;
    assign valid_decode = slot.valid;
    assign int1_decode  = slot.int1;
    assign int2_decode  = slot.int2;

    // Flush beats stall; stall freezes everything including a running interrupt sequence.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FIRST;
            slot       <= BUBBLE;
            pc_decode  <= '0;
            held_instr <= '0;
            held_pc    <= '0;
        end else if (flush) begin
            state      <= FIRST;
            slot       <= BUBBLE;
            pc_decode  <= '0;
            held_instr <= '0;
            held_pc    <= '0;
        end else if (!stall) begin
            slot      <= BUBBLE;
            pc_decode <= '0;
            case (state)
                FIRST: begin
                    if (int_take) begin
                        state <= INT1;
                    end else if (accept) begin
                        if (instr_word[IMM_FLAG_BIT]) begin
                            held_instr <= instr_word;
                            held_pc    <= pc_in;
                            state      <= WAIT_IMM;
                        end else begin
                            slot.instr <= instr_word;
                            slot.valid <= 1'b1;
                            pc_decode  <= pc_in;
                        end
                    end
                end
                WAIT_IMM: begin
                    if (accept) begin
                        slot.instr <= held_instr;
                        slot.imm   <= instr_word;
                        slot.valid <= 1'b1;
                        pc_decode  <= held_pc;
                        state      <= FIRST;
                    end
                end
                INT1: begin
                    slot.valid <= 1'b1;
                    slot.int1  <= 1'b1;
                    pc_decode  <= ret_pc;
                    state      <= INT2;
                end
                INT2: begin
                    slot.valid <= 1'b1;
                    slot.int2  <= 1'b1;
                    pc_decode  <= ret_pc;
                    state      <= FIRST;
                end
                default: state <= FIRST;
            endcase
        end
    end

endmodule
